// File: rtl/ahb_mem_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave_if
//
// Purpose:
//   AHB-Lite slave front end for a word-wide synchronous data memory.
//   Accepts word-sized, word-aligned, in-range transfers. Writes complete with
//   zero wait states. Reads insert exactly one wait state while the registered
//   memory produces its output. Misaligned, wrongly sized or out-of-range
//   transfers get the standard two-cycle ERROR response and never touch the
//   memory.
//
// Ports:
//   clk          rising-edge clock, shared with the data memory
//   reset        asynchronous, active-low reset
//   HSEL         slave select from the AHB decoder
//   HADDR        address-phase byte address
//   HTRANS       transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE       address-phase direction, 1 = write
//   HSIZE        address-phase transfer size, only word (3'b010) is legal
//   HWDATA       write data, valid in the data phase
//   HREADY       bus-level ready qualifying the address phase
//   HRDATA       read data returned to the bus
//   HREADYOUT    slave ready
//   HRESP        0 = OKAY, 1 = ERROR
//   mem_write    memory write strobe
//   mem_read     memory read strobe
//   HSEL2        memory select
//   address_ram  memory byte address
//   write_data   memory write word
//   read_data    memory read word, valid the cycle after a mem_read cycle
// ---------------------------------------------------------------------------
module ahb_mem_slave_if #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic [31:0]       HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic              mem_write,
   output logic              mem_read,
   output logic              HSEL2,
   output logic [ADDR_W-1:0] address_ram,
   output logic [31:0]       write_data,
   input  logic [31:0]       read_data
);

   localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RD_WAIT,
      ST_RD_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [2:0]        size_q, size_d;

   logic              can_accept;
   logic              accept;
   logic              legal_in;
   logic              xfer_ok_q;

   // Address phases are only taken in states where this slave is driving
   // HREADYOUT high; NONSEQ and SEQ both start a real transfer.
   always_comb begin
      can_accept = (state_q == ST_IDLE)    || (state_q == ST_WRITE) ||
                   (state_q == ST_RD_DATA) || (state_q == ST_ERR2);
      accept     = HSEL && HREADY && can_accept &&
                   ((HTRANS == 2'b10) || (HTRANS == 2'b11));
      legal_in   = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00) &&
                   (HADDR < MEM_LIMIT);
      // The registered fields are rechecked so a strobe can never fire for a
      // transfer that was not legal when captured.
      xfer_ok_q  = (size_q == 3'b010) && (addr_q[1:0] == 2'b00) &&
                   (addr_q < MEM_LIMIT);
   end

   // Next-state logic: wait and first-error cycles advance unconditionally,
   // every other state either starts the next accepted transfer or idles.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      case (state_q)
         ST_RD_WAIT: state_d = ST_RD_DATA;
         ST_ERR1:    state_d = ST_ERR2;
         default: begin
            if (accept) begin
               addr_d  = HADDR;
               write_d = HWRITE;
               size_d  = HSIZE;
               if (!legal_in) begin
                  state_d = ST_ERR1;
               end else if (HWRITE) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_RD_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // State and captured address-phase fields; reset drops any transfer in
   // flight so no memory access can follow it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 3'b000;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
      end
   end

   // Outputs decode purely from the current state, so asserting reset
   // forces the idle values immediately without waiting for a clock edge.
   always_comb begin
      HRDATA      = 32'h0;
      HREADYOUT   = 1'b1;
      HRESP       = 1'b0;
      mem_write   = 1'b0;
      mem_read    = 1'b0;
      HSEL2       = 1'b0;
      address_ram = '0;
      write_data  = 32'h0;
      case (state_q)
         ST_WRITE: begin
            HSEL2       = 1'b1;
            mem_write   = write_q && xfer_ok_q;
            address_ram = addr_q;
            write_data  = HWDATA;
         end
         ST_RD_WAIT: begin
            HSEL2       = 1'b1;
            mem_read    = !write_q && xfer_ok_q;
            address_ram = addr_q;
            HREADYOUT   = 1'b0;
         end
         ST_RD_DATA: begin
            HRDATA = read_data;
         end
         ST_ERR1: begin
            HRESP     = 1'b1;
            HREADYOUT = 1'b0;
         end
         ST_ERR2: begin
            HRESP = 1'b1;
         end
         default: begin
            HREADYOUT = 1'b1;
         end
      endcase
   end

endmodule
